osd_him_pkt: RTL and testbench
==============================

// Module: osd_him_pkt
// PURPOSE
//  Host interface module that bridges a 16-bit GLIP word stream and the DII packet network.
//  - Ingress: length-prefixed GLIP frames are turned into DII packets, with length checking.
//  - Egress: DII packets are stored whole, then sent to GLIP behind a length header word.
//  Sits between the GLIP backend and the debug ring root.
//  Successor of the fixed 8-flit HIM; adds parametrised depth/length and endianness.
//  Also adds an oversize-packet drop policy and saturating error counters.
// PARAMETERS
//  BUF_SIZE    8   egress store-and-forward depth in flits (>=2); longest egress packet
//  MAX_LEN     16  longest accepted ingress packet in flits (1..65535)
//  SWAP_BYTES  1   1: GLIP words are big-endian (swap bytes both ways); 0: pass through
//  CNT_W       16  width of error counters
// PORTS
//  clk                 in   1      clock
//  rst                 in   1      synchronous reset, active high
//  glip_in_data        in   16     host->target word
//  glip_in_valid       in   1      glip_in_data valid
//  glip_in_ready       out  1      module accepts glip_in_data
//  glip_out_data       out  16     target->host word
//  glip_out_valid      out  1      glip_out_data valid
//  glip_out_ready      in   1      host accepts glip_out_data
//  dii_out             out  dii_flit  ingress flit {data[15:0], valid, last} to the network
//  dii_out_ready       in   1      network accepts dii_out
//  dii_in              in   dii_flit  egress flit from the network
//  dii_in_ready        out  1      module accepts dii_in
//  ingress_err_cnt     out  CNT_W  ingress frames with bad length (saturating)
//  egress_drop_cnt     out  CNT_W  egress packets dropped as longer than BUF_SIZE (saturating)
// BEHAVIOUR
//  Reset: ingress state IN_HDR, egress state EG_FILL; buffer and counters are emptied/zeroed.
//   Outputs after reset: dii_out.valid=0, glip_out_valid=0.
//   Outputs after reset: glip_in_ready=1, dii_in_ready=1, counters=0.
//   Reset mid-packet discards all partial state; no flit is emitted afterwards.
//  Byte order: w' = SWAP_BYTES ? {w[7:0],w[15:8]} : w, on both directions and on headers.
//  Ingress FSM (a word is accepted when glip_in_valid & glip_in_ready):
//   IN_HDR: glip_in_ready=1. The accepted word w' gives N = w'.
//    - N==0: err_cnt+1, stay in IN_HDR.
//    - N>MAX_LEN: err_cnt+1, rem<=N, go to IN_DISCARD.
//    - Otherwise: rem<=N, go to IN_PASS.
//   IN_PASS: combinational pass-through, zero latency, no storage.
//    - dii_out.valid = glip_in_valid; dii_out.data = w'; dii_out.last = (rem==1).
//    - glip_in_ready = dii_out_ready.
//    - On accept: rem-1; when rem==1, go to IN_HDR.
//   IN_DISCARD: glip_in_ready=1, dii_out.valid=0; consume rem words, then go to IN_HDR.
//   rem is 16 bits wide, so N up to 65535 is handled in every mode.
//  Egress FSM, single packet buffer BUF_SIZE x 16, write count cnt in 0..BUF_SIZE:
//   EG_FILL: dii_in_ready=1.
//    - Accepted flit is written at cnt, cnt+1.
//    - If last: go to EG_HDR (packet length L = cnt+1).
//    - Else if cnt+1==BUF_SIZE: go to EG_DROP.
//   EG_DROP: dii_in_ready=1; flits are consumed and discarded.
//    - On last: drop_cnt+1, cnt<=0, go to EG_FILL.
//   EG_HDR: glip_out_valid=1, glip_out_data = swap(L zero-extended to 16).
//    - dii_in_ready=0.
//    - On glip_out_ready: rd<=0, go to EG_SEND.
//   EG_SEND: glip_out_valid=1, data = swap(buf[rd]).
//    - On ready: rd+1; after word L-1, cnt<=0 and go to EG_FILL.
//  Latency: header is valid on the cycle after the last flit is accepted.
//   No egress flit is accepted while in HDR/SEND.
//  A packet of exactly BUF_SIZE flits (last at cnt=BUF_SIZE-1) is sent, not dropped.
//  Counters saturate at 2^CNT_W-1.
//  Ingress and egress are independent and may be active in the same cycle.
//  glip_out_valid and dii_out.valid, once high, are held until accepted (no retraction).
// TESTING
//  1 Ingress {0x0300,A,B,C} with SWAP_BYTES=1 -> 3 flits; last on the 3rd; data byte-swapped.
//  2 Ingress header 0 then 0x1100 (N=17>MAX_LEN=16) plus 17 words, then good N=1
//    -> err_cnt=2, no flit for the bad frames, good flit delivered.
//  3 Egress 8-flit packet (BUF_SIZE=8), glip_out_ready toggling -> header L=8 then 8 words in order;
//    dii_in_ready=0 during send.
//  4 Egress 9-flit packet -> no GLIP output, drop_cnt=1; the next 2-flit packet is sent normally.
//  5 dii_out_ready=0 for 5 cycles mid ingress packet -> glip_in_ready=0, no data lost or duplicated.
//  6 rst asserted mid egress send and mid ingress pass -> all valids 0 the next cycle, counters 0;
//    a new packet then works.

Source files
------------

// File: rtl/osd_him_pkt_if.sv
// Handshake bundle between the HIM and its two neighbours: the GLIP word stream and the DII flit ports.
// The master modport is the HIM side; the slave modport is the host/network side.
interface osd_him_pkt_if;
  logic [15:0] glip_in_data;
  logic        glip_in_valid;
  logic        glip_in_ready;
  logic [15:0] glip_out_data;
  logic        glip_out_valid;
  logic        glip_out_ready;
  logic [15:0] dii_out_data;
  logic        dii_out_valid;
  logic        dii_out_last;
  logic        dii_out_ready;
  logic [15:0] dii_in_data;
  logic        dii_in_valid;
  logic        dii_in_last;
  logic        dii_in_ready;

  modport master (
    input  glip_in_data, glip_in_valid, output glip_in_ready,
    output glip_out_data, glip_out_valid, input glip_out_ready,
    output dii_out_data, dii_out_valid, dii_out_last, input dii_out_ready,
    input  dii_in_data, dii_in_valid, dii_in_last, output dii_in_ready
  );

  modport slave (
    output glip_in_data, glip_in_valid, input glip_in_ready,
    input  glip_out_data, glip_out_valid, output glip_out_ready,
    input  dii_out_data, dii_out_valid, dii_out_last, output dii_out_ready,
    output dii_in_data, dii_in_valid, dii_in_last, input dii_in_ready
  );
endinterface

// File: rtl/osd_him_pkt.sv
// Host interface module: length-prefixed GLIP frames become DII packets (ingress, pass-through),
// DII packets are buffered whole and sent to GLIP behind a length header (egress).
module osd_him_pkt #(
  parameter int BUF_SIZE   = 8,
  parameter int MAX_LEN    = 16,
  parameter int SWAP_BYTES = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  osd_him_pkt_if.master    io_bus,
  output logic [CNT_W-1:0] o_ingress_err_cnt,
  output logic [CNT_W-1:0] o_egress_drop_cnt
);
  localparam int AW = (BUF_SIZE > 1) ? $clog2(BUF_SIZE) : 1;
  localparam int CW = $clog2(BUF_SIZE + 1);
  localparam logic [CW-1:0] BUF_LAST  = CW'(BUF_SIZE - 1);
  localparam logic [16:0]   MAX_LEN_V = 17'(MAX_LEN);

  function automatic logic [15:0] f_swap(input logic [15:0] w);
    return (SWAP_BYTES != 0) ? {w[7:0], w[15:8]} : w;
  endfunction

  typedef enum logic [1:0] {IN_HDR, IN_PASS, IN_DISCARD} in_state_t;
  typedef enum logic [1:0] {EG_FILL, EG_DROP, EG_HDR, EG_SEND} eg_state_t;

  in_state_t        r_in_state, w_in_state_next;
  eg_state_t        r_eg_state, w_eg_state_next;
  logic [15:0]      r_rem, w_rem_next;
  logic [CNT_W-1:0] r_err_cnt, r_drop_cnt;
  logic             w_err_inc, w_drop_inc;
  logic [15:0]      w_in_word;
  logic [CW-1:0]    r_cnt, w_cnt_next;
  logic [AW-1:0]    r_rd, w_rd_next;
  logic             w_we;
  logic [15:0]      r_buf [BUF_SIZE];
  logic [15:0]      r_rd_data;

  assign w_in_word         = f_swap(io_bus.glip_in_data);
  assign o_ingress_err_cnt = r_err_cnt;
  assign o_egress_drop_cnt = r_drop_cnt;

  // Ingress: the payload is a zero-latency combinational path from GLIP to DII.
  always_comb begin
    w_in_state_next      = r_in_state;
    w_rem_next           = r_rem;
    w_err_inc            = 1'b0;
    io_bus.glip_in_ready = 1'b0;
    io_bus.dii_out_valid = 1'b0;
    io_bus.dii_out_data  = w_in_word;
    io_bus.dii_out_last  = (r_rem == 16'd1);
    case (r_in_state)
      IN_HDR: begin
        io_bus.glip_in_ready = 1'b1;
        if (io_bus.glip_in_valid) begin
          if (w_in_word == 16'd0) begin
            w_err_inc = 1'b1;
          end else if ({1'b0, w_in_word} > MAX_LEN_V) begin
            w_err_inc       = 1'b1;
            w_rem_next      = w_in_word;
            w_in_state_next = IN_DISCARD;
          end else begin
            w_rem_next      = w_in_word;
            w_in_state_next = IN_PASS;
          end
        end
      end
      IN_PASS: begin
        io_bus.dii_out_valid = io_bus.glip_in_valid;
        io_bus.glip_in_ready = io_bus.dii_out_ready;
        if (io_bus.glip_in_valid && io_bus.dii_out_ready) begin
          w_rem_next = r_rem - 16'd1;
          if (r_rem == 16'd1) w_in_state_next = IN_HDR;
        end
      end
      IN_DISCARD: begin
        io_bus.glip_in_ready = 1'b1;
        if (io_bus.glip_in_valid) begin
          w_rem_next = r_rem - 16'd1;
          if (r_rem == 16'd1) w_in_state_next = IN_HDR;
        end
      end
      default: w_in_state_next = IN_HDR;
    endcase
  end

  // Egress: read address is looked ahead one cycle so the buffer read can be registered.
  always_comb begin
    w_eg_state_next       = r_eg_state;
    w_cnt_next            = r_cnt;
    w_rd_next             = r_rd;
    w_we                  = 1'b0;
    w_drop_inc            = 1'b0;
    io_bus.dii_in_ready   = 1'b0;
    io_bus.glip_out_valid = 1'b0;
    io_bus.glip_out_data  = f_swap(r_rd_data);
    case (r_eg_state)
      EG_FILL: begin
        io_bus.dii_in_ready = 1'b1;
        if (io_bus.dii_in_valid) begin
          w_we       = 1'b1;
          w_cnt_next = r_cnt + 1'b1;
          if (io_bus.dii_in_last)     w_eg_state_next = EG_HDR;
          else if (r_cnt == BUF_LAST) w_eg_state_next = EG_DROP;
        end
      end
      EG_DROP: begin
        io_bus.dii_in_ready = 1'b1;
        if (io_bus.dii_in_valid && io_bus.dii_in_last) begin
          w_drop_inc      = 1'b1;
          w_cnt_next      = '0;
          w_eg_state_next = EG_FILL;
        end
      end
      EG_HDR: begin
        io_bus.glip_out_valid = 1'b1;
        io_bus.glip_out_data  = f_swap(16'(r_cnt));
        w_rd_next             = '0;
        if (io_bus.glip_out_ready) w_eg_state_next = EG_SEND;
      end
      EG_SEND: begin
        io_bus.glip_out_valid = 1'b1;
        if (io_bus.glip_out_ready) begin
          if (CW'(r_rd) == r_cnt - 1'b1) begin
            w_rd_next       = '0;
            w_cnt_next      = '0;
            w_eg_state_next = EG_FILL;
          end else begin
            w_rd_next = r_rd + 1'b1;
          end
        end
      end
      default: w_eg_state_next = EG_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_state <= IN_HDR;
      r_eg_state <= EG_FILL;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_rd       <= '0;
      r_err_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_in_state <= w_in_state_next;
      r_eg_state <= w_eg_state_next;
      r_rem      <= w_rem_next;
      r_cnt      <= w_cnt_next;
      r_rd       <= w_rd_next;
      if (w_err_inc && (r_err_cnt != '1))   r_err_cnt  <= r_err_cnt + 1'b1;
      if (w_drop_inc && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  // Packet store: written only while filling, so no reset is needed on the array.
  always_ff @(posedge clk) begin
    if (w_we) r_buf[r_cnt[AW-1:0]] <= io_bus.dii_in_data;
    r_rd_data <= r_buf[w_rd_next];
  end
endmodule

// File: tb/tb_osd_him_pkt.sv
// Scoreboard bench for osd_him_pkt: stimulus pushes expected flits/words, a negedge monitor pops and compares.
module tb_osd_him_pkt;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] err_cnt, drop_cnt;
  int          checks = 0;
  int          errors = 0;
  int          out_mode = 1;  // 0 ready low, 1 ready high, 2 toggle, 3 manual
  logic [16:0] exp_dii[$];    // {last, data}
  logic [15:0] exp_glip[$];
  logic [16:0] mon_d;
  logic [15:0] mon_g;

  always #5 clk = ~clk;

  osd_him_pkt_if bus_if();

  osd_him_pkt #(.BUF_SIZE(8), .MAX_LEN(16), .SWAP_BYTES(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .io_bus(bus_if),
    .o_ingress_err_cnt(err_cnt), .o_egress_drop_cnt(drop_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic glip_put(input logic [15:0] w);
    bus_if.glip_in_data  = w;
    bus_if.glip_in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus_if.glip_in_ready) begin
        @(posedge clk); #1;
        bus_if.glip_in_valid = 1'b0;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL glip_put_timeout: word %h not accepted, required accept within 200 cycles", w);
    bus_if.glip_in_valid = 1'b0;
  endtask

  task automatic dii_put(input logic [15:0] d, input logic l);
    bus_if.dii_in_data  = d;
    bus_if.dii_in_last  = l;
    bus_if.dii_in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus_if.dii_in_ready) begin
        @(posedge clk); #1;
        bus_if.dii_in_valid = 1'b0;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL dii_put_timeout: flit %h not accepted, required accept within 200 cycles", d);
    bus_if.dii_in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 2000; n++) begin
      if (exp_dii.size() == 0 && exp_glip.size() == 0) break;
      @(negedge clk);
    end
    check(name, 32'(exp_dii.size() + exp_glip.size()), 32'd0);
  endtask

  // glip_out_ready pattern driver
  initial begin
    bus_if.glip_out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (out_mode)
        0: bus_if.glip_out_ready = 1'b0;
        1: bus_if.glip_out_ready = 1'b1;
        2: bus_if.glip_out_ready = ~bus_if.glip_out_ready;
        default: ;
      endcase
    end
  end

  // Monitor: outputs sampled at negedge, a handshake completes on the following posedge
  initial begin
    forever begin
      @(negedge clk);
      if (bus_if.dii_out_valid && bus_if.dii_out_ready) begin
        if (exp_dii.size() == 0) begin
          checks++; errors++;
          $display("FAIL dii_unexpected: got flit %h last %b, required none", bus_if.dii_out_data, bus_if.dii_out_last);
        end else begin
          mon_d = exp_dii.pop_front();
          check("dii_flit", {15'd0, bus_if.dii_out_last, bus_if.dii_out_data}, {15'd0, mon_d});
        end
      end
      if (bus_if.glip_out_valid && bus_if.glip_out_ready) begin
        if (exp_glip.size() == 0) begin
          checks++; errors++;
          $display("FAIL glip_unexpected: got word %h, required none", bus_if.glip_out_data);
        end else begin
          mon_g = exp_glip.pop_front();
          check("glip_word", {16'd0, bus_if.glip_out_data}, {16'd0, mon_g});
        end
      end
      if (bus_if.glip_out_valid && !rst)
        check("dii_in_ready_while_sending", {31'd0, bus_if.dii_in_ready}, 32'd0);
    end
  end

  initial begin
    bus_if.glip_in_data  = '0;
    bus_if.glip_in_valid = 1'b0;
    bus_if.dii_in_data   = '0;
    bus_if.dii_in_valid  = 1'b0;
    bus_if.dii_in_last   = 1'b0;
    bus_if.dii_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dii_out_valid",  {31'd0, bus_if.dii_out_valid},  32'd0);
    check("rst_glip_out_valid", {31'd0, bus_if.glip_out_valid}, 32'd0);
    check("rst_glip_in_ready",  {31'd0, bus_if.glip_in_ready},  32'd1);
    check("rst_dii_in_ready",   {31'd0, bus_if.dii_in_ready},   32'd1);
    check("rst_err_cnt",  {16'd0, err_cnt},  32'd0);
    check("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    rst = 1'b0;

    // 1: three-flit ingress frame, bytes swapped, last on the third
    exp_dii.push_back(17'h0_3412);
    exp_dii.push_back(17'h0_7856);
    exp_dii.push_back(17'h1_BC9A);
    glip_put(16'h0300); glip_put(16'h1234); glip_put(16'h5678); glip_put(16'h9ABC);
    drain("t1_drain");

    // 2: zero-length and oversize frames are counted and swallowed
    glip_put(16'h0000);
    check("t2_err_after_zero", {16'd0, err_cnt}, 32'd1);
    glip_put(16'h1100);
    for (int i = 0; i < 17; i++) glip_put(16'hDEAD);
    check("t2_err_after_big", {16'd0, err_cnt}, 32'd2);
    exp_dii.push_back(17'h1_ABCD);
    glip_put(16'h0100); glip_put(16'hCDAB);
    drain("t2_drain");

    // boundary: N == MAX_LEN is accepted
    for (int i = 0; i < 16; i++) exp_dii.push_back({(i == 15), 8'(i), 8'h00});
    glip_put(16'h1000);
    for (int i = 0; i < 16; i++) glip_put({8'h00, 8'(i)});
    drain("t2_maxlen_drain");
    check("t2_err_unchanged", {16'd0, err_cnt}, 32'd2);

    // 5: network back-pressure for 5 cycles mid-frame
    exp_dii.push_back(17'h0_1101);
    exp_dii.push_back(17'h0_2202);
    exp_dii.push_back(17'h0_3303);
    exp_dii.push_back(17'h1_4404);
    glip_put(16'h0400); glip_put(16'h0111); glip_put(16'h0222);
    bus_if.glip_in_data  = 16'h0333;
    bus_if.glip_in_valid = 1'b1;
    bus_if.dii_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_stall_glip_in_ready", {31'd0, bus_if.glip_in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    bus_if.dii_out_ready = 1'b1;
    glip_put(16'h0333); glip_put(16'h0444);
    drain("t5_drain");

    // 3: full-size egress packet with toggling host ready
    out_mode = 2;
    exp_glip.push_back(16'h0800);
    for (int i = 0; i < 8; i++) exp_glip.push_back({8'(i), 8'hA0});
    for (int i = 0; i < 8; i++) dii_put(16'hA000 + 16'(i), (i == 7));
    drain("t3_drain");

    // 4: nine-flit packet is dropped, the next one goes through
    out_mode = 1;
    for (int i = 0; i < 9; i++) dii_put(16'hEE00 + 16'(i), (i == 8));
    check("t4_drop_cnt", {16'd0, drop_cnt}, 32'd1);
    exp_glip.push_back(16'h0200);
    exp_glip.push_back(16'h3412);
    exp_glip.push_back(16'h7856);
    dii_put(16'h1234, 1'b0); dii_put(16'h5678, 1'b1);
    drain("t4_drain");

    // 6: reset in the middle of an egress send and an ingress pass
    out_mode = 3;
    @(posedge clk); #1;
    bus_if.glip_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) dii_put(16'h1111 * 16'(i + 1), (i == 3));
    exp_glip.push_back(16'h0400);
    exp_glip.push_back(16'h1111);
    bus_if.glip_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus_if.glip_out_ready = 1'b0;
    exp_dii.push_back(17'h0_1122);
    glip_put(16'h0300); glip_put(16'h2211);
    bus_if.dii_out_ready = 1'b0;
    bus_if.glip_in_data  = 16'h4433;
    bus_if.glip_in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    bus_if.glip_in_valid = 1'b0;
    @(posedge clk); #1;
    check("t6_glip_out_valid", {31'd0, bus_if.glip_out_valid}, 32'd0);
    check("t6_dii_out_valid",  {31'd0, bus_if.dii_out_valid},  32'd0);
    check("t6_err_cnt",  {16'd0, err_cnt},  32'd0);
    check("t6_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    check("t6_queues_empty", 32'(exp_dii.size() + exp_glip.size()), 32'd0);
    rst = 1'b0;
    bus_if.dii_out_ready = 1'b1;
    out_mode = 1;
    exp_dii.push_back(17'h1_6677);
    glip_put(16'h0100); glip_put(16'h7766);
    exp_glip.push_back(16'h0100);
    exp_glip.push_back(16'h0201);
    dii_put(16'h0102, 1'b1);
    drain("t6_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
